// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch stage in front of inst_rom.
//
// Owns the fetch PC, runs the ROM chip-select / stall handshake, and queues
// returned words in a 2-entry FIFO that decode drains via valid/ready.
// A redirect flushes the FIFO and restarts fetch at the new PC.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   rom_cs       ROM chip select, held for the whole read (registered)
//   rom_addr     ROM word address = pc[31:2]
//   rom_dout     ROM read data, meaningful only in an ack cycle
//   rom_stall    ROM busy; ack = rom_cs & ~rom_stall
//   redirect     one-cycle pulse: discard current stream
//   redirect_pc  new byte PC (bits [1:0] forced to zero)
//   id_ready     decode takes the head entry this cycle
//   if_valid     head entry valid (registered)
//   if_inst      head instruction (registered)
//   if_pc        head byte PC (registered)
//
// Build option:
//   INST_FETCH_ABORT_EN  defined   -> a flush drops rom_cs for one cycle,
//                                      aborting any read in flight.
//                        undefined -> a flush lets the in-flight read finish
//                                      at its old address and discards its data.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FETCH | normal streaming; rom_cs high whenever the FIFO has a free slot
// S_FLUSH | after a redirect; old stream being discarded before refetch

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_cs,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_dout,
  input  logic        rom_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [29:0] word_q, word_n;
  logic [1:0]  count, count_n;
  logic [1:0]  fill;
  logic        slot;
  logic [31:0] q_inst   [2];
  logic [31:0] q_inst_n [2];
  logic [31:0] q_pc     [2];
  logic [31:0] q_pc_n   [2];
  logic        cs_n;
  logic        valid_n;
  logic        ack;
  logic        push;
  logic        pop;
`ifndef INST_FETCH_ABORT_EN
  // an old-stream read is still outstanding while in S_FLUSH
  logic        pend, pend_n;
`endif

  assign rom_addr = {2'b00, word_q};
  assign if_inst  = q_inst[0];
  assign if_pc    = q_pc[0];

  assign ack  = rom_cs & ~rom_stall;
  // Acks seen in S_FLUSH belong to the discarded stream.
  assign push = (state == S_FETCH) & ack & ~redirect;
  assign pop  = if_valid & id_ready & ~redirect;

  always_comb begin
    q_inst_n = q_inst;
    q_pc_n   = q_pc;
    pc_n     = pc;
    count_n  = count;
    fill     = 2'd0;
    slot     = 1'b0;
    state_n  = state;
    cs_n     = 1'b0;
    word_n   = word_q;
    valid_n  = 1'b0;
`ifndef INST_FETCH_ABORT_EN
    pend_n   = pend;
`endif

    // FIFO: head is entry 0; a pop shifts entry 1 down, then a push lands
    // in the first slot free after that shift.
    if (redirect) begin
      count_n = 2'd0;
      pc_n    = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        q_inst_n[0] = q_inst[1];
        q_pc_n[0]   = q_pc[1];
      end
      fill = count - {1'b0, pop};
      slot = (fill != 2'd0);
      if (push) begin
        q_inst_n[slot] = rom_dout;
        q_pc_n[slot]   = pc;
        pc_n           = pc + 32'd4;
      end
      count_n = count + {1'b0, push} - {1'b0, pop};
    end

`ifdef INST_FETCH_ABORT_EN
    if (redirect) begin
      state_n = S_FLUSH;
    end else if (state == S_FLUSH) begin
      state_n = S_FETCH;
    end
    // One cycle of rom_cs low in S_FLUSH is enough to reset the ROM.
    cs_n   = (state_n == S_FETCH) && (count_n != 2'd2);
    word_n = pc_n[31:2];
`else
    if (redirect) begin
      state_n = S_FLUSH;
      // A read that acks in the redirect cycle is already finished.
      pend_n  = rom_cs & ~ack;
    end else if ((state == S_FLUSH) && (!pend || ack)) begin
      state_n = S_FETCH;
      pend_n  = 1'b0;
    end
    if (state_n == S_FLUSH) begin
      // Keep the old read alive at its original address until it acks.
      cs_n   = pend_n;
      word_n = word_q;
    end else begin
      cs_n   = (count_n != 2'd2);
      word_n = pc_n[31:2];
    end
`endif

    valid_n = (count_n != 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      word_q    <= RESET_PC[31:2];
      count     <= 2'd0;
      q_inst[0] <= 32'd0;
      q_inst[1] <= 32'd0;
      q_pc[0]   <= 32'd0;
      q_pc[1]   <= 32'd0;
      rom_cs    <= 1'b0;
      if_valid  <= 1'b0;
`ifndef INST_FETCH_ABORT_EN
      pend      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      word_q    <= word_n;
      count     <= count_n;
      q_inst[0] <= q_inst_n[0];
      q_inst[1] <= q_inst_n[1];
      q_pc[0]   <= q_pc_n[0];
      q_pc[1]   <= q_pc_n[1];
      rom_cs    <= cs_n;
      if_valid  <= valid_n;
`ifndef INST_FETCH_ABORT_EN
      pend      <= pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch with a behavioural inst_rom (CLK_DELAY = rom_delay).
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef INST_FETCH_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_cs;
  logic [31:0] rom_addr;
  logic [31:0] rom_dout;
  logic        rom_stall;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_dout(rom_dout), .rom_stall(rom_stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  // ROM model: a read is rom_delay+2 cycles of cs, the last one the ack.
  logic [31:0] mem [64];
  int          rom_delay = 8;
  logic [7:0]  rom_cnt;
  logic        rom_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rom_cnt <= 8'd0;
    else if (!rom_cs || !rom_stall) rom_cnt <= 8'd0;
    else rom_cnt <= rom_cnt + 8'd1;
  end

  always_comb begin
    rom_stall = (rom_cnt != 8'(rom_delay + 1));
    rom_ack   = rom_cs && !rom_stall;
    rom_dout  = rom_ack ? mem[rom_addr[5:0]] : (32'hBAD0_0000 | 32'(rom_cnt));
  end

  function automatic logic [31:0] mem_at(input logic [31:0] byte_pc);
    return mem[byte_pc[7:2]];
  endfunction

  task automatic do_reset(input int d);
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
    rom_delay = d;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int first_cs, v1, v2, nvalid;
    logic [31:0] p1, p2, i1, i2;
    rst = 1'b0; redirect = 1'b0; id_ready = 1'b0; rom_delay = 8;
    repeat (2) @(negedge clk);
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs got=%0h exp=0", rom_cs); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%0h exp=0", if_valid); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
    checks++; if (rom_addr !== {2'b00, RST_PC[31:2]}) begin errors++; $display("FAIL reset_rom_addr got=%h exp=%h", rom_addr, {2'b00, RST_PC[31:2]}); end
    rst = 1'b1; id_ready = 1'b1;
    first_cs = -1; v1 = -1; v2 = -1; nvalid = 0;
    p1 = 0; p2 = 0; i1 = 0; i2 = 0;
    for (int cyc = 0; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (rom_cs === 1'b1 && first_cs < 0) first_cs = cyc;
      if (if_valid === 1'b1) begin
        nvalid++;
        if (v1 < 0) begin v1 = cyc; p1 = if_pc; i1 = if_inst; end
        else if (v2 < 0) begin v2 = cyc; p2 = if_pc; i2 = if_inst; end
      end
    end
    checks++; if (first_cs != 0) begin errors++; $display("FAIL first_cs_cycle got=%0d exp=0", first_cs); end
    checks++; if (v1 != 10) begin errors++; $display("FAIL first_valid_cycle got=%0d exp=10", v1); end
    checks++; if (p1 !== RST_PC || i1 !== mem_at(RST_PC)) begin errors++; $display("FAIL first_entry got=%h/%h exp=%h/%h", p1, i1, RST_PC, mem_at(RST_PC)); end
    checks++; if (v2 != 20) begin errors++; $display("FAIL second_valid_cycle got=%0d exp=20", v2); end
    checks++; if (p2 !== RST_PC + 4 || i2 !== mem_at(RST_PC + 4)) begin errors++; $display("FAIL second_entry got=%h/%h exp=%h/%h", p2, i2, RST_PC + 4, mem_at(RST_PC + 4)); end
    checks++; if (nvalid != 2) begin errors++; $display("FAIL valid_cycle_count got=%0d exp=2", nvalid); end
  endtask

  task automatic test_backpressure();
    int ncs;
    do_reset(8);
    ncs = 0;
    for (int cyc = 0; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (rom_cs === 1'b1) ncs++;
    end
    checks++; if (ncs != 20) begin errors++; $display("FAIL bp_cs_cycles got=%0d exp=20", ncs); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL bp_full_cs got=%0h exp=0", rom_cs); end
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_inst !== mem_at(RST_PC)) begin
      errors++; $display("FAIL bp_head got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, RST_PC, mem_at(RST_PC)); end
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 4 || if_inst !== mem_at(RST_PC + 4)) begin
      errors++; $display("FAIL bp_after_pop got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, RST_PC + 4, mem_at(RST_PC + 4)); end
    checks++; if (rom_cs !== 1'b1 || rom_addr !== {2'b00, RST_PC[31:2]} + 32'd2) begin
      errors++; $display("FAIL bp_refetch got=%0h/%h exp=1/%h", rom_cs, rom_addr, {2'b00, RST_PC[31:2]} + 32'd2); end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_mid_read();
    int new_cs, fv, exp_new_cs, exp_fv;
    logic [31:0] fp, fi;
    exp_new_cs = ABORT ? 7 : 10;
    exp_fv     = ABORT ? 17 : 20;
    do_reset(8);
    id_ready = 1'b1;
    new_cs = -1; fv = -1; fp = 0; fi = 0;
    for (int cyc = 0; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 6) begin
        checks++; if (rom_cs !== !ABORT) begin errors++; $display("FAIL redir_flush_cs got=%0h exp=%0h", rom_cs, !ABORT); end
      end
      if (!ABORT && cyc >= 6 && cyc <= 9) begin
        checks++; if (rom_cs !== 1'b1 || rom_addr !== 32'd0) begin
          errors++; $display("FAIL redir_old_addr cyc=%0d got=%0h/%h exp=1/0", cyc, rom_cs, rom_addr); end
      end
      if (cyc > 5 && new_cs < 0 && rom_cs === 1'b1 && rom_addr === 32'd8) new_cs = cyc;
      if (fv < 0 && if_valid === 1'b1) begin fv = cyc; fp = if_pc; fi = if_inst; end
      redirect = (cyc == 5);
      redirect_pc = 32'h0000_0023;
    end
    checks++; if (new_cs != exp_new_cs) begin errors++; $display("FAIL redir_new_cs_cycle got=%0d exp=%0d", new_cs, exp_new_cs); end
    checks++; if (fv != exp_fv) begin errors++; $display("FAIL redir_first_valid got=%0d exp=%0d", fv, exp_fv); end
    checks++; if (fp !== 32'h20 || fi !== mem_at(32'h20)) begin errors++; $display("FAIL redir_first_entry got=%h/%h exp=00000020/%h", fp, fi, mem_at(32'h20)); end
  endtask

  task automatic test_redirect_ack_pop();
    int fv;
    logic [31:0] fp, fi;
    do_reset(8);
    fv = -1; fp = 0; fi = 0;
    for (int cyc = 0; cyc <= 35; cyc++) begin
      @(negedge clk);
      if (cyc == 19) begin
        checks++; if (rom_ack !== 1'b1 || if_valid !== 1'b1) begin
          errors++; $display("FAIL ackpop_setup got ack=%0h valid=%0h exp=1/1", rom_ack, if_valid); end
      end
      if (cyc == 20) begin
        checks++; if (if_valid !== 1'b0 || rom_cs !== 1'b0) begin
          errors++; $display("FAIL ackpop_flushed got valid=%0h cs=%0h exp=0/0", if_valid, rom_cs); end
      end
      if (cyc == 21) begin
        checks++; if (rom_cs !== 1'b1 || rom_addr !== 32'h10) begin
          errors++; $display("FAIL ackpop_refetch got=%0h/%h exp=1/00000010", rom_cs, rom_addr); end
      end
      if (cyc > 19 && fv < 0 && if_valid === 1'b1) begin fv = cyc; fp = if_pc; fi = if_inst; end
      redirect = (cyc == 19);
      redirect_pc = 32'h0000_0040;
      if (cyc == 19) id_ready = 1'b1;
    end
    checks++; if (fv != 31) begin errors++; $display("FAIL ackpop_first_valid got=%0d exp=31", fv); end
    checks++; if (fp !== 32'h40 || fi !== mem_at(32'h40)) begin errors++; $display("FAIL ackpop_first_entry got=%h/%h exp=00000040/%h", fp, fi, mem_at(32'h40)); end
  endtask

  task automatic test_async_reset();
    int fv;
    logic [31:0] fp;
    do_reset(8);
    repeat (13) @(negedge clk);
    checks++; if (rom_cs !== 1'b1 || if_valid !== 1'b1) begin
      errors++; $display("FAIL arst_setup got cs=%0h valid=%0h exp=1/1", rom_cs, if_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rom_cs !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'd0 || if_inst !== 32'd0) begin
      errors++; $display("FAIL arst_async got cs=%0h valid=%0h pc=%h inst=%h exp=0/0/0/0", rom_cs, if_valid, if_pc, if_inst); end
    @(negedge clk);
    rst = 1'b1; id_ready = 1'b1;
    fv = -1; fp = 0;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++; if (rom_cs !== 1'b1 || rom_addr !== {2'b00, RST_PC[31:2]}) begin
          errors++; $display("FAIL arst_restart got=%0h/%h exp=1/%h", rom_cs, rom_addr, {2'b00, RST_PC[31:2]}); end
      end
      if (fv < 0 && if_valid === 1'b1) begin fv = cyc; fp = if_pc; end
    end
    checks++; if (fv != 10 || fp !== RST_PC) begin errors++; $display("FAIL arst_first_entry got=%0d/%h exp=10/%h", fv, fp, RST_PC); end
  endtask

  // Reference: decode must see consecutive PCs from the last redirect target
  // (or RESET_PC), each paired with that word of memory; rom_addr may only
  // move once the outstanding read has acked or been dropped.
  task automatic test_random(input int d, input int n);
    logic [31:0] exp_pc, prev_addr;
    logic prev_cs, prev_ack;
    int pops;
    do_reset(d);
    exp_pc = RST_PC; pops = 0;
    prev_cs = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      if (prev_cs && !prev_ack && rom_cs === 1'b1) begin
        checks++; if (rom_addr !== prev_addr) begin
          errors++; $display("FAIL rand_addr_stable cyc=%0d got=%h exp=%h", cyc, rom_addr, prev_addr); end
      end
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 29) == 0);
      if (redirect) redirect_pc = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)));
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (if_valid === 1'b1 && id_ready) begin
        checks++; if (if_pc !== exp_pc || if_inst !== mem_at(exp_pc)) begin
          errors++; $display("FAIL rand_pop cyc=%0d got=%h/%h exp=%h/%h", cyc, if_pc, if_inst, exp_pc, mem_at(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_cs = (rom_cs === 1'b1); prev_ack = (rom_ack === 1'b1); prev_addr = rom_addr;
    end
    redirect = 1'b0;
    checks++; if (pops < n / ((d + 2) * 4)) begin errors++; $display("FAIL rand_throughput d=%0d got=%0d exp>=%0d", d, pops, n / ((d + 2) * 4)); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_backpressure();
    test_redirect_mid_read();
    test_redirect_ack_pop();
    test_async_reset();
    test_random(2, 2000);
    test_random(0, 2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage placed directly upstream of `inst_rom`. It owns the PC, drives the ROM chip-select/address handshake, and captures each returned word into a 2-entry instruction queue that feeds decode through a valid/ready interface. Branch/jump redirects flush the queue and restart fetch at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_cs`  out  1  ROM chip select; held high for the whole read.
- `rom_addr`  out  32  word address to ROM, equal to `{2'b00, pc[31:2]}`.
- `rom_dout`  in  32  ROM read data; valid only in an ack cycle.
- `rom_stall`  in  1  ROM busy. An ack cycle is any cycle with `rom_cs=1` and `rom_stall=0`.
- `redirect`  in  1  one-cycle pulse from execute: discard the current stream.
- `redirect_pc`  in  32  new byte PC; bits [1:0] are ignored and forced to 0.
- `id_ready`  in  1  decode accepts the head entry this cycle.
- `if_valid`  out  1  head queue entry is valid.
- `if_inst`  out  32  head instruction.
- `if_pc`  out  32  byte PC of the head instruction.

## Operation
- State: `pc` (next fetch address), 2-entry FIFO of {inst, pc}, `count` 0..2, FSM state in {S_FETCH, S_FLUSH}.
- Reset values: `pc=RESET_PC`, `count=0`, state S_FETCH, `if_valid=0`, `if_inst=0`, `if_pc=0`.
- `rom_cs = (state==S_FETCH) && (count<2)`. A read in flight never sees `count` increase, so `rom_cs` and `rom_addr` stay stable until ack.
- Ack cycle in S_FETCH with no redirect: push {`rom_dout`, `pc`}, then `pc <= pc + 4` (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Pop when `if_valid && id_ready`. Push and pop in the same cycle leave `count` unchanged; the queue order is preserved.
- The queue cannot overflow: there is at most one read in flight, and `rom_cs=0` when `count==2`.
- Redirect, any state: `count <= 0`, `pc <= {redirect_pc[31:2],2'b00}`, state <= S_FLUSH. An ack in the same cycle is discarded, and a pop in the same cycle is ignored.
- S_FLUSH: behaviour depends on the Configuration macro. Exits to S_FETCH.
- A redirect during S_FLUSH reloads `pc` and restarts S_FLUSH.
- Reset asserted mid-read forces `rom_cs=0` immediately; the ROM's `~cs` path clears its counter.

## Timing
- Capture happens at the clock edge ending the ack cycle. `if_valid` is high the following cycle.
- With a ROM whose CLK_DELAY=D, each read occupies D+2 cycles of `rom_cs` high, including the ack cycle. The ROM returns to idle after an ack, so back-to-back fetches run at 1 instruction per D+2 cycles.
- `if_valid`, `if_inst` and `if_pc` are registered queue-head outputs with no combinational path from `id_ready`.
- Redirect-to-first-new-`rom_cs`: 2 cycles with the abort feature; see Configuration for the non-abort case.

## Configuration
- `INST_FETCH_ABORT_EN` defined:
  - S_FLUSH lasts exactly one cycle with `rom_cs=0`. This aborts any in-flight ROM read, because the ROM clears its counter and returns to idle.
  - S_FETCH resumes at the new `pc` on the next cycle.
- Not defined:
  - S_FLUSH keeps `rom_cs=1` with `rom_addr` frozen at the old address until that read's ack.
  - That ack's data is dropped and not pushed; S_FETCH then resumes at the new `pc` on the next cycle.
  - If no read was in flight at redirect time, S_FLUSH lasts one cycle with `rom_cs=0`.

## Test plan
- Reset release, `RESET_PC=0`, ROM D=8, `id_ready=1` -> `rom_cs=1` from cycle 0; first `if_valid` with `if_pc=0`, `if_inst=mem[0]` after 10 cycles. The next entry has `if_pc=4` 10 cycles later.
- `id_ready=0` held -> after two acks `count=2` and `rom_cs=0`. `if_pc` stays at 0. Raising `id_ready` for one cycle shows `if_pc=4` next and re-asserts `rom_cs`.
- Redirect to 32'h0000_0023 at cycle 5 of a read, macro defined -> `rom_cs=0` for 1 cycle, then `rom_addr=8`. The first new `if_pc` is 32'h20, and no old-stream entry appears.
- Same redirect, macro undefined -> `rom_addr` stays at the old address until ack. That data is dropped, then `rom_addr=8`, and the first `if_pc` is 32'h20.
- Redirect coincident with an ack cycle and a pop -> `count=0` next cycle and the acked word never appears at `if_inst`.
- `rst` pulled low mid-read -> `rom_cs`, `if_valid` and `if_pc` go to 0 asynchronously. After release, fetch restarts at `RESET_PC`.
